// File: rtl/div_iter_unit.sv
// div_iter_unit: multi-cycle radix-2 restoring divider, signed or unsigned.
// Produces one quotient bit per clock and returns {remainder, quotient}.
// div_end is high whenever the unit is idle and can accept a request.
module div_iter_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  div_start,
    input  logic                  div_op,
    input  logic [DATA_W-1:0]     dividend,
    input  logic [DATA_W-1:0]     divisor,
    output logic [2*DATA_W-1:0]   div_result,
    output logic                  div_end,
    output logic                  div_valid
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] dvs_mag;
    logic [DATA_W-1:0] dvd_raw;
    logic              op_signed;
    logic              dvd_neg;
    logic              dvs_neg;
    logic              dvs_zero;

    logic              start_ok;
    logic [DATA_W-1:0] dvd_mag_in;
    logic [DATA_W-1:0] dvs_mag_in;
    logic [DATA_W:0]   rem_shift;
    logic [DATA_W:0]   trial;
    logic [DATA_W-1:0] quo_fix;
    logic [DATA_W-1:0] rem_fix;

    // Flush always wins over a new request.
    assign start_ok = div_start & ~flush;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> CALC -> FIX -> IDLE, flush aborts to IDLE
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start_ok) state_nxt = CALC;
            CALC: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (cnt == LAST_ITER) begin
                    state_nxt = FIX;
                end
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: ready exactly when idle
    always_comb begin
        div_end = (state == IDLE);
    end

    // Operand magnitudes: two's-complement absolute value in signed mode
    always_comb begin
        dvd_mag_in = (div_op && dividend[DATA_W-1]) ? -dividend : dividend;
        dvs_mag_in = (div_op && divisor[DATA_W-1])  ? -divisor  : divisor;
    end

    // One restoring step: shift the next dividend bit in, try subtracting
    always_comb begin
        rem_shift = {rem, quo[DATA_W-1]};
        trial     = rem_shift - {1'b0, dvs_mag};
    end

    // Sign restoration; a zero divisor bypasses it and returns the raw dividend
    always_comb begin
        quo_fix = (op_signed && (dvd_neg ^ dvs_neg)) ? -quo : quo;
        rem_fix = (op_signed && dvd_neg) ? -rem : rem;
        if (dvs_zero) begin
            quo_fix = '1;
            rem_fix = dvd_raw;
        end
    end

    // Datapath: operand capture, iteration registers and result write
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            rem        <= '0;
            quo        <= '0;
            dvs_mag    <= '0;
            dvd_raw    <= '0;
            op_signed  <= 1'b0;
            dvd_neg    <= 1'b0;
            dvs_neg    <= 1'b0;
            dvs_zero   <= 1'b0;
            div_result <= '0;
            div_valid  <= 1'b0;
        end else begin
            div_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_ok) begin
                        op_signed <= div_op;
                        dvd_neg   <= div_op & dividend[DATA_W-1];
                        dvs_neg   <= div_op & divisor[DATA_W-1];
                        dvs_zero  <= (divisor == '0);
                        dvd_raw   <= dividend;
                        quo       <= dvd_mag_in;
                        dvs_mag   <= dvs_mag_in;
                        rem       <= '0;
                        cnt       <= '0;
                    end
                end
                CALC: begin
                    if (!flush) begin
                        cnt <= cnt + 1'b1;
                        if (!trial[DATA_W]) begin
                            rem <= trial[DATA_W-1:0];
                            quo <= {quo[DATA_W-2:0], 1'b1};
                        end else begin
                            rem <= rem_shift[DATA_W-1:0];
                            quo <= {quo[DATA_W-2:0], 1'b0};
                        end
                    end
                end
                FIX: begin
                    if (!flush) begin
                        div_result <= {rem_fix, quo_fix};
                        div_valid  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter_unit.sv
// tb_div_iter_unit: directed vectors for div_iter_unit, checked every cycle
// against an arithmetic reference model plus hand-computed literal results.
module tb_div_iter_unit;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic           flush;
    logic           div_start;
    logic           div_op;
    logic [W-1:0]   dividend;
    logic [W-1:0]   divisor;
    logic [2*W-1:0] div_result;
    logic           div_end;
    logic           div_valid;

    int checks   = 0;
    int failures = 0;

    div_iter_unit #(.DATA_W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .div_start  (div_start),
        .div_op     (div_op),
        .dividend   (dividend),
        .divisor    (divisor),
        .div_result (div_result),
        .div_end    (div_end),
        .div_valid  (div_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference result from plain integer arithmetic (truncating division)
    function automatic logic [63:0] model_div(input logic op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Behavioural timing model: busy for DATA_W+1 edges after an accepted start
    logic        m_busy   = 1'b0;
    logic        m_valid  = 1'b0;
    logic [63:0] m_result = '0;
    logic [63:0] m_pend   = '0;
    int          m_left   = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy   = 1'b0;
            m_valid  = 1'b0;
            m_result = '0;
            m_left   = 0;
        end else begin
            m_valid = 1'b0;
            if (!m_busy) begin
                if (div_start && !flush) begin
                    m_busy = 1'b1;
                    m_left = W + 1;
                    m_pend = model_div(div_op, dividend, divisor);
                end
            end else if (flush) begin
                m_busy = 1'b0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_busy   = 1'b0;
                    m_valid  = 1'b1;
                    m_result = m_pend;
                end
            end
        end
    end

    // Per-cycle compare against the model
    logic chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_div_end", {63'd0, div_end}, {63'd0, !m_busy});
            check("cyc_div_valid", {63'd0, div_valid}, {63'd0, m_valid});
            check("cyc_div_result", div_result, m_result);
        end
    end

    // Issue at the current negedge (cycle 0), wait for div_valid, check latency/result.
    // poke > 0 raises a conflicting div_start in that cycle while busy.
    task automatic run_div(input string nm, input logic op, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int poke);
        int n;
        div_start = 1'b1;
        div_op    = op;
        dividend  = a;
        divisor   = b;
        @(negedge clk);
        n = 1;
        div_start = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        check({nm, "_busy"}, {63'd0, div_end}, 64'd0);
        while (!div_valid && n < 60) begin
            if (n == poke) begin
                div_start = 1'b1;
                div_op    = ~op;
                dividend  = 32'd99;
                divisor   = 32'd1;
            end
            @(negedge clk);
            n++;
            div_start = 1'b0;
            dividend  = $urandom;
            divisor   = $urandom;
        end
        check({nm, "_latency"}, 64'(n), 64'd34);
        check({nm, "_result"}, div_result, exp);
        check({nm, "_end"}, {63'd0, div_end}, 64'd1);
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        div_start = 1'b0;
        div_op    = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_end", {63'd0, div_end}, 64'd1);
        check("rst_valid", {63'd0, div_valid}, 64'd0);
        check("rst_result", div_result, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_div("u100_7",   1'b0, 32'd100,       32'd7,         64'h00000002_0000000E, 0);
        run_div("s_m7_2",   1'b1, 32'hFFFFFFF9,  32'd2,         64'hFFFFFFFF_FFFFFFFD, 0);
        run_div("s_7_m2",   1'b1, 32'd7,         32'hFFFFFFFE,  64'h00000001_FFFFFFFD, 0);
        run_div("u_ff_1",   1'b0, 32'hFFFFFFFF,  32'd1,         64'h00000000_FFFFFFFF, 0);
        run_div("s_ovf",    1'b1, 32'h80000000,  32'hFFFFFFFF,  64'h00000000_80000000, 0);
        run_div("u_dz",     1'b0, 32'h12345678,  32'd0,         64'h12345678_FFFFFFFF, 0);
        run_div("s_dz",     1'b1, 32'h12345678,  32'd0,         64'h12345678_FFFFFFFF, 0);
        run_div("s_dz_neg", 1'b1, 32'h80000001,  32'd0,         64'h80000001_FFFFFFFF, 0);
        run_div("s_m100_7", 1'b1, 32'hFFFFFF9C,  32'd7,         64'hFFFFFFFE_FFFFFFF2, 0);
        run_div("s_m8_m3",  1'b1, 32'hFFFFFFF8,  32'hFFFFFFFD,  64'hFFFFFFFE_00000002, 0);
        run_div("u_5_10",   1'b0, 32'd5,         32'd10,        64'h00000005_00000000, 0);
        run_div("u_ff_ff",  1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  64'h00000000_00000001, 0);
        run_div("busy_ign", 1'b0, 32'd100,       32'd7,         64'h00000002_0000000E, 5);

        // Flush in CALC at cycle 10, restart at cycle 11
        div_start = 1'b1; div_op = 1'b0; dividend = 32'd1000; divisor = 32'd3;
        @(negedge clk);
        div_start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_end", {63'd0, div_end}, 64'd1);
        check("flush_valid", {63'd0, div_valid}, 64'd0);
        run_div("after_flush", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 0);

        // Flush coincident with the FIX edge suppresses the write
        @(negedge clk);
        div_start = 1'b1; div_op = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(negedge clk);
        div_start = 1'b0;
        repeat (32) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fixflush_end", {63'd0, div_end}, 64'd1);
        check("fixflush_valid", {63'd0, div_valid}, 64'd0);
        check("fixflush_hold", div_result, 64'hFFFFFFFF_FFFFFFFD);
        repeat (2) @(negedge clk);

        // Reset mid-operation at cycle 20
        div_start = 1'b1; div_op = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(negedge clk);
        div_start = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_end", {63'd0, div_end}, 64'd1);
        check("midrst_result", div_result, 64'd0);
        check("midrst_valid", {63'd0, div_valid}, 64'd0);

        // div_start together with flush in IDLE is ignored
        div_start = 1'b1; flush = 1'b1; div_op = 1'b0; dividend = 32'd50; divisor = 32'd5;
        @(negedge clk);
        div_start = 1'b0; flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("sf_idle_end", {63'd0, div_end}, 64'd1);
            @(negedge clk);
        end
        check("sf_idle_valid", {63'd0, div_valid}, 64'd0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
